// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master driven by a valid/ready command stream
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d, to_hit, to_fire;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = wstrb_q;
  assign m_axi_wvalid = wvalid_q;
  assign m_axi_bready = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready = rready_q;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  // Next state: one AXI phase per state, phase counter restarts on every phase entry
  always_comb begin
    state_d = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d = rsp_resp_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d = cnt_q + CW'(1);
    to_fire = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        cmd_ready_d = 1'b0;
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
        cnt_d = '0;
        state_d = cmd_we ? WRITE : READ;
        awvalid_d = cmd_we;
        wvalid_d = cmd_we;
        arvalid_d = !cmd_we;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
      end
      WRITE: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || (awvalid_q && m_axi_awready)) && (w_done_q || (wvalid_q && m_axi_wready))) begin
          state_d = WRESP;
          bready_d = 1'b1;
          cnt_d = '0;
        end else to_fire = to_hit;
      end
      WRESP: if (m_axi_bvalid && bready_q) begin
        bready_d = 1'b0;
        rsp_resp_d = m_axi_bresp;
        rsp_rdata_d = '0;
        rsp_timeout_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end else to_fire = to_hit;
      READ: if (arvalid_q && m_axi_arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        cnt_d = '0;
        state_d = RDATA;
      end else to_fire = to_hit;
      RDATA: if (m_axi_rvalid && rready_q) begin
        rready_d = 1'b0;
        rsp_resp_d = m_axi_rresp;
        rsp_rdata_d = m_axi_rdata;
        rsp_timeout_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end else to_fire = to_hit;
      RESP: if (rsp_valid_q && rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (to_fire) begin
      awvalid_d = 1'b0;
      wvalid_d = 1'b0;
      bready_d = 1'b0;
      arvalid_d = 1'b0;
      rready_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_resp_d = 2'b10;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d = '0;
      state_d = RESP;
    end
  end
  // Register every output and the latched command; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q <= rsp_resp_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: vector table plus corner-case sequences against a stub register-file slave
module tb_axi_lite_cmd_master;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0, rsp_valid, rsp_ready = 1, rsp_timeout;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, rsp_rdata;
  logic [3:0] cmd_wstrb = 0;
  logic [1:0] rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Stub slave: 4-word register file at 0x00-0x0C, SLVERR elsewhere, B/R one cycle after the address phase
  int aw_lat = 0, w_lat = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit ar_en = 1, b_en = 1, have_aw = 0, have_w = 0, have_ar = 0;
  logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
  logic [3:0] s_wstrb = 0;
  logic [31:0] smem [4] = '{default: 32'h0};
  assign awready = awvalid && aw_cnt >= aw_lat;
  assign wready = wvalid && w_cnt >= w_lat;
  assign arready = ar_en && arvalid;
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; have_aw <= 0; have_w <= 0; have_ar <= 0;
      bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin have_aw <= 1; s_awaddr <= awaddr; end
      if (wvalid && wready) begin have_w <= 1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if (have_aw && have_w && !bvalid && b_en) begin
        bvalid <= 1; have_aw <= 0; have_w <= 0;
        bresp <= (s_awaddr < 32'h10) ? 2'b00 : 2'b10;
        if (s_awaddr < 32'h10)
          for (int b = 0; b < 4; b++) if (s_wstrb[b]) smem[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
      if (bvalid && bready) begin bvalid <= 0; b_cnt <= b_cnt + 1; end
      if (arvalid && arready) begin have_ar <= 1; s_araddr <= araddr; end
      if (have_ar && !rvalid) begin
        rvalid <= 1; have_ar <= 0;
        rdata <= (s_araddr < 32'h10) ? smem[s_araddr[3:2]] : 32'h0;
        rresp <= (s_araddr < 32'h10) ? 2'b00 : 2'b10;
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  // Scoreboard and observers sampled on the falling edge
  typedef struct {logic [31:0] rdata; logic [1:0] resp; logic to;} exp_t;
  exp_t sb[$];
  int cyc = 0, rise_cyc = 0, rsp_cnt = 0, ar_hi = 0;
  bit rv_prev = 0, both_seen = 0, split_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = rsp_valid;
    if (awvalid && wvalid) both_seen = 1;
    if (awvalid && !wvalid) split_seen = 1;
    if (arvalid) ar_hi++;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
      rsp_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc_cyc = 0;
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    for (int i = 0; i < 200 && !cmd_ready; i++) tick();
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rsp_cnt < n; i++) tick();
    chk("rsp_arrived", rsp_cnt >= n, 1);
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic [1:0] ep, input logic et);
    int n;
    n = rsp_cnt + 1;
    sb.push_back('{er, ep, et});
    issue(we, a, d, s);
    wait_rsp(n);
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    chk("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
  endtask

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] rdata; logic [1:0] resp;} vec_t;
  vec_t vt[9];

  initial begin
    int n;
    vt[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
    vt[1] = '{1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    vt[2] = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b10};
    vt[3] = '{1'b1, 32'h08, 32'h12345678, 4'h3, 32'h0, 2'b00};
    vt[4] = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h00005678, 2'b00};
    vt[5] = '{1'b1, 32'h40, 32'h55555555, 4'hF, 32'h0, 2'b10};
    vt[6] = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 32'h0, 2'b00};
    vt[7] = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'hAABBCCDD, 2'b00};
    vt[8] = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00};
    repeat (3) tick();
    chk_reset_state();
    chk("prot_fixed", {awprot, arprot}, 6'b0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 9; i++) begin
      both_seen = 0;
      do_cmd(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].rdata, vt[i].resp, 1'b0);
      chk($sformatf("latency_%0d", i), rise_cyc - acc_cyc, 4);
      if (vt[i].we) chk($sformatf("aw_w_together_%0d", i), both_seen, 1);
    end
    // W completes three cycles before AW
    aw_lat = 3; split_seen = 0; n = b_cnt;
    do_cmd(1'b1, 32'h00, 32'h11223344, 4'hF, 32'h0, 2'b00, 1'b0);
    chk("w_before_aw_split", split_seen, 1);
    chk("w_before_aw_one_b", b_cnt - n, 1);
    aw_lat = 0;
    do_cmd(1'b0, 32'h00, 32'h0, 4'h0, 32'h11223344, 2'b00, 1'b0);
    // AR never accepted: times out after 16 cycles in READ
    ar_en = 0; ar_hi = 0;
    do_cmd(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1);
    chk("timeout_ar_cycles", ar_hi, 16);
    chk("timeout_arvalid_low", arvalid, 0);
    ar_en = 1;
    do_cmd(1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 1'b0);
    // Response back-pressure with a competing command held on the input
    rsp_ready = 0; n = rsp_cnt;
    sb.push_back('{32'hAABBCCDD, 2'b00, 1'b0});
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    sb.push_back('{32'h00005678, 2'b00, 1'b0});
    cmd_we = 0; cmd_addr = 32'h08; cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, 32'hAABBCCDD, 2'b00, 1'b0});
      chk("hold_busy", {cmd_ready, arvalid, awvalid}, 3'b000);
      tick();
    end
    rsp_ready = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("hold_release_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    wait_rsp(n + 2);
    // Reset while waiting for B
    b_en = 0;
    sb.push_back('{32'h0, 2'b00, 1'b0});
    issue(1'b1, 32'h00, 32'h99999999, 4'hF);
    for (int i = 0; i < 20 && !bready; i++) tick();
    chk("wresp_reached", bready, 1);
    rst_n = 0;
    tick();
    chk_reset_state();
    void'(sb.pop_back());
    rst_n = 1; b_en = 1;
    tick();
    chk("no_rsp_after_reset", rsp_valid, 0);
    do_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 32'hAABBCCDD, 2'b00, 1'b0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
